// File: rtl/radix_sort_lsd_pkg.sv
// Shared types and helpers for the LSD radix sorter: FSM states, pass count and
// per-pass digit extraction (sign flip, digit select, descending remap).
package radix_sort_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, PREFIX, SCATTER, UNLOAD} state_t;

  function automatic int passes(input int width, input int rb);
    return (width + rb - 1) / rb;
  endfunction

  // Flipping the sign bit maps two's complement order onto unsigned order;
  // bits above the key width read as zero in a short final digit.
  function automatic logic [31:0] digit_of(input logic [63:0] key, input logic [31:0] pass,
                                           input logic desc, input logic sgn,
                                           input logic [31:0] width, input logic [31:0] rb);
    logic [63:0] k;
    logic [31:0] dmax;
    logic [31:0] d;
    k = key & ((64'd1 << width) - 64'd1);
    if (sgn) k = k ^ (64'd1 << (width - 32'd1));
    k = k >> (pass * rb);
    dmax = (32'd1 << rb) - 32'd1;
    d = 32'(k) & dmax;
    if (desc) d = dmax - d;
    return d;
  endfunction

endpackage

// File: rtl/radix_sort_lsd_bucket_table.sv
// Bucket counter table: B counters of IDXW bits, one clear/increment/prefix-step per cycle.
// rd_val is the pre-update value of the addressed counter (the scatter destination).
module radix_bucket_table #(
  parameter int RB   = 4,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic            pfx,
  input  logic [RB-1:0]   idx,
  output logic [IDXW-1:0] rd_val
);
  localparam int B = 1 << RB;

  logic [B-1:0][IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0]        acc_q, acc_d;

  assign rd_val = cnt_q[idx];

  // A prefix step replaces the counter with the running sum of all lower buckets.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (inc) begin
      cnt_d[idx] = cnt_q[idx] + IDXW'(1);
    end else if (pfx) begin
      cnt_d[idx] = acc_q;
      acc_d      = acc_q + cnt_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/radix_sort_lsd.sv
// LSD radix sorter: streaming load, PASSES x (count, prefix, scatter) stable
// counting-sort passes ping-ponging between two buffers, then streaming unload.
module radix_sort_lsd
  import radix_sort_pkg::*;
#(
  parameter int N          = 8,
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_desc,
  input  logic             cfg_signed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  localparam int B      = 1 << RADIX_BITS;
  localparam int PASSES = passes(WIDTH, RADIX_BITS);
  localparam int IDXW   = $clog2(N + 1);
  localparam int AW     = (N > 1) ? $clog2(N) : 1;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX  = IDXW'(N - 1);
  localparam logic [PW-1:0]         LAST_PASS = PW'(PASSES - 1);
  localparam logic [RADIX_BITS-1:0] LAST_BKT  = RADIX_BITS'(B - 1);

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [RADIX_BITS-1:0]       bkt_q, bkt_d;
  logic [PW-1:0]               pass_q, pass_d;
  logic                        desc_q, desc_d, sgn_q, sgn_d;
  logic [WIDTH-1:0]            out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [N-1:0][WIDTH-1:0]     buf_a_q, buf_a_d, buf_b_q, buf_b_d, fin_q;

  logic                        tbl_clr, tbl_inc, tbl_pfx;
  logic [RADIX_BITS-1:0]       tbl_idx, dig;
  logic [IDXW-1:0]             tbl_rd, idx_nx;
  logic [WIDTH-1:0]            src_key;

  // Even passes read buf_a and write buf_b; odd passes the reverse.
  assign src_key = pass_q[0] ? buf_b_q[AW'(idx_q)] : buf_a_q[AW'(idx_q)];
  assign fin_q   = pass_q[0] ? buf_a_q : buf_b_q;
  assign dig     = RADIX_BITS'(digit_of(64'(src_key), 32'(pass_q), desc_q, sgn_q,
                                        32'(WIDTH), 32'(RADIX_BITS)));
  assign idx_nx  = idx_q + IDXW'(1);
  assign tbl_idx = (state_q == PREFIX) ? bkt_q : dig;

  radix_bucket_table #(.RB(RADIX_BITS), .IDXW(IDXW)) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .clr    (tbl_clr),
    .inc    (tbl_inc),
    .pfx    (tbl_pfx),
    .idx    (tbl_idx),
    .rd_val (tbl_rd)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bkt_d       = bkt_q;
    pass_d      = pass_q;
    desc_d      = desc_q;
    sgn_d       = sgn_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    tbl_clr     = 1'b0;
    tbl_inc     = 1'b0;
    tbl_pfx     = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (in_valid) begin
          buf_a_d[AW'(idx_q)] = in_data;
          if (state_q == IDLE) begin
            desc_d = cfg_desc;
            sgn_d  = cfg_signed;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            pass_d  = '0;
            tbl_clr = 1'b1;
            state_d = COUNT;
          end else begin
            idx_d   = idx_nx;
            state_d = LOAD;
          end
        end
      end
      COUNT: begin
        tbl_inc = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          bkt_d   = '0;
          state_d = PREFIX;
        end else begin
          idx_d = idx_nx;
        end
      end
      PREFIX: begin
        tbl_pfx = 1'b1;
        if (bkt_q == LAST_BKT) state_d = SCATTER;
        else                   bkt_d   = bkt_q + RADIX_BITS'(1);
      end
      SCATTER: begin
        tbl_inc = 1'b1;
        if (pass_q[0]) buf_a_d[AW'(tbl_rd)] = src_key;
        else           buf_b_d[AW'(tbl_rd)] = src_key;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (pass_q == LAST_PASS) begin
            // The final scatter write may land on slot 0, so present the post-write value.
            out_data_d  = pass_q[0] ? buf_a_d[0] : buf_b_d[0];
            out_valid_d = 1'b1;
            out_last_d  = (N == 1);
            state_d     = UNLOAD;
          end else begin
            pass_d  = pass_q + PW'(1);
            tbl_clr = 1'b1;
            state_d = COUNT;
          end
        end else begin
          idx_d = idx_nx;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            idx_d      = idx_nx;
            out_data_d = fin_q[AW'(idx_nx)];
            out_last_d = (idx_nx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bkt_q       <= '0;
      pass_q      <= '0;
      desc_q      <= 1'b0;
      sgn_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bkt_q       <= bkt_d;
      pass_q      <= pass_d;
      desc_q      <= desc_d;
      sgn_q       <= sgn_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Key storage carries no reset; every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    buf_a_q <= buf_a_d;
    buf_b_q <= buf_b_d;
  end

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
